// File: rtl/ucsbece154b_mem_arbiter.sv
// Shares one external memory port between the I-cache refill path (block bursts)
// and the data load/store path (single words). Ties are broken round-robin.
module ucsbece154b_mem_arbiter #(
   parameter int BLOCK_WORDS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           IReq_i,
   input  logic [ADDR_W-1:0]              IAddr_i,
   output logic [DATA_W-1:0]              IRData_o,
   output logic                           IRValid_o,
   output logic [$clog2(BLOCK_WORDS)-1:0] IWordIdx_o,
   output logic                           IDone_o,
   input  logic                           DReq_i,
   input  logic                           DWE_i,
   input  logic [ADDR_W-1:0]              DAddr_i,
   input  logic [DATA_W-1:0]              DWData_i,
   output logic [DATA_W-1:0]              DRData_o,
   output logic                           DReady_o,
   output logic                           MemReq_o,
   output logic                           MemWE_o,
   output logic [ADDR_W-1:0]              MemAddr_o,
   output logic [4:0]                     MemLen_o,
   output logic [DATA_W-1:0]              MemWData_o,
   input  logic [DATA_W-1:0]              MemRData_i,
   input  logic                           MemRValid_i,
   input  logic                           MemWAck_i,
   output logic [1:0]                     Owner_o
);

   localparam int                IDX_W      = $clog2(BLOCK_WORDS);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((BLOCK_WORDS * 4) - 1);
   localparam logic [4:0]        LEN_I      = 5'(BLOCK_WORDS);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_BURST = 2'd1,
      D_READ  = 2'd2,
      D_WRITE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic                r_lastGrantD;
   logic [IDX_W-1:0]    r_cnt;
   logic                r_memReq;
   logic                r_memWE;
   logic [ADDR_W-1:0]   r_memAddr;
   logic [4:0]          r_memLen;
   logic                w_grantI;
   logic                w_beat;
   logic                w_lastBeat;
   logic                w_dRead;
   logic                w_dWrite;

   // I wins a tie unless it was the last one granted
   assign w_grantI   = IReq_i && (!DReq_i || r_lastGrantD);
   assign w_beat     = (r_state == I_BURST) && MemRValid_i;
   assign w_lastBeat = w_beat && (r_cnt == LAST_IDX);
   assign w_dRead    = (r_state == D_READ) && MemRValid_i;
   assign w_dWrite   = (r_state == D_WRITE) && MemWAck_i;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_grantI)
               w_nextState = I_BURST;
            else if (DReq_i)
               w_nextState = DWE_i ? D_WRITE : D_READ;
         end
         I_BURST: if (w_lastBeat) w_nextState = IDLE;
         D_READ:  if (w_dRead)    w_nextState = IDLE;
         D_WRITE: if (w_dWrite)   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Command fields are latched at grant and held until the transaction ends
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_lastGrantD <= 1'b1;
         r_cnt        <= '0;
         r_memReq     <= 1'b0;
         r_memWE      <= 1'b0;
         r_memAddr    <= '0;
         r_memLen     <= '0;
      end else begin
         r_state  <= w_nextState;
         r_memReq <= 1'b0;
         if (r_state == IDLE && w_nextState != IDLE) begin
            r_memReq     <= 1'b1;
            r_lastGrantD <= (w_nextState != I_BURST);
            r_memAddr    <= (w_nextState == I_BURST) ? (IAddr_i & ALIGN_MASK) : DAddr_i;
            r_memLen     <= (w_nextState == I_BURST) ? LEN_I : 5'd1;
            r_memWE      <= (w_nextState == D_WRITE);
         end else if (r_state != IDLE && w_nextState == IDLE) begin
            r_memWE   <= 1'b0;
            r_memAddr <= '0;
            r_memLen  <= '0;
         end
         if (w_beat)
            r_cnt <= w_lastBeat ? '0 : r_cnt + IDX_W'(1);
      end
   end

   assign MemReq_o   = r_memReq;
   assign MemWE_o    = r_memWE;
   assign MemAddr_o  = r_memAddr;
   assign MemLen_o   = r_memLen;
   assign MemWData_o = (r_state == D_WRITE) ? DWData_i : '0;

   assign IRValid_o  = w_beat;
   assign IRData_o   = w_beat ? MemRData_i : '0;
   assign IWordIdx_o = r_cnt;
   assign IDone_o    = w_lastBeat;

   assign DReady_o   = w_dRead || w_dWrite;
   assign DRData_o   = w_dRead ? MemRData_i : '0;

   assign Owner_o    = (r_state == IDLE) ? 2'd0 : (r_state == I_BURST) ? 2'd1 : 2'd2;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Bench for ucsbece154b_mem_arbiter: a vector table of transactions served by a small
// memory model, with expected commands/beats/responses queued and checked by a monitor.
module tb_ucsbece154b_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        IReq_i;
   logic [31:0] IAddr_i;
   logic [31:0] IRData_o;
   logic        IRValid_o;
   logic [1:0]  IWordIdx_o;
   logic        IDone_o;
   logic        DReq_i;
   logic        DWE_i;
   logic [31:0] DAddr_i;
   logic [31:0] DWData_i;
   logic [31:0] DRData_o;
   logic        DReady_o;
   logic        MemReq_o;
   logic        MemWE_o;
   logic [31:0] MemAddr_o;
   logic [4:0]  MemLen_o;
   logic [31:0] MemWData_o;
   logic [31:0] MemRData_i;
   logic        MemRValid_i;
   logic        MemWAck_i;
   logic [1:0]  Owner_o;

   int vecCount = 0;
   int missCount = 0;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      int          gapSeed;
   } vec_t;

   typedef struct {
      logic [1:0]  owner;
      logic [31:0] addr;
      logic [4:0]  len;
      logic        we;
   } cmd_t;

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] data;
      logic        done;
      logic [31:0] addr;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic        checkData;
   } dresp_t;

   cmd_t   cmdQ[$];
   beat_t  iQ[$];
   dresp_t dQ[$];

   ucsbece154b_mem_arbiter #(
      .BLOCK_WORDS(4),
      .ADDR_W(32),
      .DATA_W(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .IReq_i(IReq_i),
      .IAddr_i(IAddr_i),
      .IRData_o(IRData_o),
      .IRValid_o(IRValid_o),
      .IWordIdx_o(IWordIdx_o),
      .IDone_o(IDone_o),
      .DReq_i(DReq_i),
      .DWE_i(DWE_i),
      .DAddr_i(DAddr_i),
      .DWData_i(DWData_i),
      .DRData_o(DRData_o),
      .DReady_o(DReady_o),
      .MemReq_o(MemReq_o),
      .MemWE_o(MemWE_o),
      .MemAddr_o(MemAddr_o),
      .MemLen_o(MemLen_o),
      .MemWData_o(MemWData_o),
      .MemRData_i(MemRData_i),
      .MemRValid_i(MemRValid_i),
      .MemWAck_i(MemWAck_i),
      .Owner_o(Owner_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One compare, one count; a mismatch is reported with both values
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every command strobe, I beat and D completion must match the queues
   always @(negedge clk) begin
      cmd_t   c;
      beat_t  b;
      dresp_t d;
      if (MemReq_o === 1'b1) begin
         if (cmdQ.size() == 0)
            checkOutput("unexpected MemReq", 1, 0);
         else begin
            c = cmdQ.pop_front();
            checkOutput("cmd owner", Owner_o, c.owner);
            checkOutput("cmd addr", MemAddr_o, c.addr);
            checkOutput("cmd len", MemLen_o, c.len);
            checkOutput("cmd we", MemWE_o, c.we);
         end
      end
      if (IRValid_o === 1'b1) begin
         if (iQ.size() == 0)
            checkOutput("unexpected IRValid", 1, 0);
         else begin
            b = iQ.pop_front();
            checkOutput("beat idx", IWordIdx_o, b.idx);
            checkOutput("beat data", IRData_o, b.data);
            checkOutput("beat done", IDone_o, b.done);
            checkOutput("addr held", MemAddr_o, b.addr);
         end
      end else if (IDone_o !== 1'b0)
         checkOutput("IDone without beat", IDone_o, 0);
      if (DReady_o === 1'b1) begin
         if (dQ.size() == 0)
            checkOutput("unexpected DReady", 1, 0);
         else begin
            d = dQ.pop_front();
            if (d.checkData)
               checkOutput("load data", DRData_o, d.data);
         end
      end
   end

   task automatic pushExpect(input vec_t v);
      logic [31:0] aligned;
      aligned = v.addr & ~32'hF;
      if (v.kind == 0) begin
         cmdQ.push_back('{owner: 2'd1, addr: aligned, len: 5'd4, we: 1'b0});
         for (int k = 0; k < 4; k++)
            iQ.push_back('{idx: 2'(k), data: v.rdata + 32'(k), done: (k == 3), addr: aligned});
      end else if (v.kind == 1) begin
         cmdQ.push_back('{owner: 2'd2, addr: v.addr, len: 5'd1, we: 1'b0});
         dQ.push_back('{data: v.rdata, checkData: 1'b1});
      end else begin
         cmdQ.push_back('{owner: 2'd2, addr: v.addr, len: 5'd1, we: 1'b1});
         dQ.push_back('{data: 32'h0, checkData: 1'b0});
      end
   endtask

   task automatic driveRequest(input vec_t v);
      if (v.kind == 0) begin
         IReq_i  = 1'b1;
         IAddr_i = v.addr;
      end else begin
         DReq_i   = 1'b1;
         DWE_i    = (v.kind == 2);
         DAddr_i  = v.addr;
         DWData_i = v.wdata;
      end
   endtask

   // Memory model: waits for a command, then answers it and drops the owner's request
   task automatic serveOne(input int lat, input int gapSeed, input logic [31:0] rbase,
                           input logic [31:0] wdata);
      int         n;
      int         len;
      logic [1:0] own;
      logic       we;
      n = 0;
      while (MemReq_o !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (MemReq_o !== 1'b1) begin
         checkOutput("MemReq timeout", 0, 1);
         IReq_i = 1'b0;
         DReq_i = 1'b0;
         return;
      end
      own = Owner_o;
      we  = MemWE_o;
      len = int'(MemLen_o);
      if (len < 1 || len > 16) len = 4;
      if (own == 2'd1) begin
         repeat (lat) begin @(posedge clk); #1; end
         for (int k = 0; k < len; k++) begin
            MemRValid_i = 1'b1;
            MemRData_i  = rbase + 32'(k);
            @(posedge clk); #1;
            MemRValid_i = 1'b0;
            MemRData_i  = '0;
            if (k == len - 1)
               IReq_i = 1'b0;
            else if (gapSeed >= 0)
               repeat ((gapSeed + k) % 4) begin @(posedge clk); #1; end
         end
      end else if (!we) begin
         repeat (lat) begin @(posedge clk); #1; end
         MemRValid_i = 1'b1;
         MemRData_i  = rbase;
         @(posedge clk); #1;
         MemRValid_i = 1'b0;
         MemRData_i  = '0;
         DReq_i      = 1'b0;
      end else begin
         for (int c = 0; c <= lat; c++) begin
            checkOutput("MemWData held", MemWData_o, wdata);
            checkOutput("MemWE held", MemWE_o, 1);
            if (c == lat) MemWAck_i = 1'b1;
            @(posedge clk); #1;
         end
         MemWAck_i = 1'b0;
         DReq_i    = 1'b0;
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      pushExpect(v);
      driveRequest(v);
      serveOne(v.lat, v.gapSeed, v.rdata, v.wdata);
      checkOutput("owner back to none", Owner_o, 0);
      checkOutput("cmd queue drained", cmdQ.size(), 0);
      checkOutput("beat queue drained", iQ.size(), 0);
      checkOutput("resp queue drained", dQ.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs[6];
      vec_t ti;
      vec_t td;

      vecs[0] = '{kind: 0, addr: 32'h0000_104C, wdata: 32'h0,           rdata: 32'hA000_0000, lat: 3, gapSeed: -1};
      vecs[1] = '{kind: 1, addr: 32'h2000_0008, wdata: 32'h0,           rdata: 32'hDEAD_BEEF, lat: 5, gapSeed: -1};
      vecs[2] = '{kind: 2, addr: 32'h3000_0004, wdata: 32'h1234_5678,   rdata: 32'h0,         lat: 2, gapSeed: -1};
      vecs[3] = '{kind: 0, addr: 32'h0000_2FFF, wdata: 32'h0,           rdata: 32'hB000_0010, lat: 1, gapSeed: 0};
      vecs[4] = '{kind: 0, addr: 32'hFFFF_FFF8, wdata: 32'h0,           rdata: 32'hC000_0020, lat: 2, gapSeed: 1};
      vecs[5] = '{kind: 1, addr: 32'h0000_0000, wdata: 32'h0,           rdata: 32'h0000_0000, lat: 1, gapSeed: -1};

      reset       = 1'b0;
      IReq_i      = 1'b0;
      IAddr_i     = '0;
      DReq_i      = 1'b0;
      DWE_i       = 1'b0;
      DAddr_i     = '0;
      DWData_i    = '0;
      MemRData_i  = '0;
      MemRValid_i = 1'b0;
      MemWAck_i   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset Owner", Owner_o, 0);
      checkOutput("reset MemReq", MemReq_o, 0);
      checkOutput("reset MemAddr", MemAddr_o, 0);
      checkOutput("reset MemLen", MemLen_o, 0);
      checkOutput("reset IWordIdx", IWordIdx_o, 0);
      checkOutput("reset DReady", DReady_o, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Stray memory responses while idle must be ignored
      MemRValid_i = 1'b1;
      MemRData_i  = 32'h5555_AAAA;
      MemWAck_i   = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checkOutput("idle IRValid", IRValid_o, 0);
         checkOutput("idle DReady", DReady_o, 0);
         checkOutput("idle IDone", IDone_o, 0);
         @(posedge clk); #1;
      end
      MemRValid_i = 1'b0;
      MemWAck_i   = 1'b0;
      MemRData_i  = '0;
      checkOutput("idle counter", IWordIdx_o, 0);

      for (int i = 0; i < 6; i++)
         applyStimulus(vecs[i]);

      // Two ties: I must win the first, then alternate I, D, I, D
      for (int t = 0; t < 2; t++) begin
         ti = '{kind: 0, addr: 32'h0000_4010 + 32'(t * 64), wdata: 32'h0, rdata: 32'hE000_0000 + 32'(t * 16), lat: 2, gapSeed: -1};
         td = '{kind: 1 + t, addr: 32'h2000_0100 + 32'(t * 4), wdata: 32'hCAFE_0000 + 32'(t), rdata: 32'h7777_0000 + 32'(t), lat: 2, gapSeed: -1};
         pushExpect(ti);
         pushExpect(td);
         driveRequest(ti);
         driveRequest(td);
         serveOne(ti.lat, ti.gapSeed, ti.rdata, ti.wdata);
         checkOutput("tie gap owner", Owner_o, 0);
         serveOne(td.lat, td.gapSeed, td.rdata, td.wdata);
         checkOutput("tie cmd queue drained", cmdQ.size(), 0);
         checkOutput("tie beat queue drained", iQ.size(), 0);
         checkOutput("tie resp queue drained", dQ.size(), 0);
      end

      // Reset lands mid-burst after two beats
      cmdQ.push_back('{owner: 2'd1, addr: 32'h0000_5000, len: 5'd4, we: 1'b0});
      for (int k = 0; k < 2; k++)
         iQ.push_back('{idx: 2'(k), data: 32'hD000_0000 + 32'(k), done: 1'b0, addr: 32'h0000_5000});
      IReq_i  = 1'b1;
      IAddr_i = 32'h0000_5008;
      begin
         int n;
         n = 0;
         while (MemReq_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         checkOutput("reset-seq MemReq", MemReq_o, 1);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         MemRValid_i = 1'b1;
         MemRData_i  = 32'hD000_0000 + 32'(k);
         @(posedge clk); #1;
      end
      MemRData_i = 32'hD000_0002;
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async reset IRValid", IRValid_o, 0);
      checkOutput("async reset IDone", IDone_o, 0);
      checkOutput("async reset IRData", IRData_o, 0);
      checkOutput("async reset Owner", Owner_o, 0);
      checkOutput("async reset MemAddr", MemAddr_o, 0);
      checkOutput("async reset MemLen", MemLen_o, 0);
      checkOutput("async reset counter", IWordIdx_o, 0);
      IReq_i      = 1'b0;
      MemRValid_i = 1'b0;
      MemRData_i  = '0;
      checkOutput("reset-seq beats consumed", iQ.size(), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      applyStimulus('{kind: 0, addr: 32'h0000_5008, wdata: 32'h0, rdata: 32'hF000_0000, lat: 1, gapSeed: 2});

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
